ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/bk_ps2_pkg.sv | 23 ++
 rtl/ps2_filter.sv | 64 ++++++
 rtl/ps2_rx_fifo.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bk_ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, prefix codes and the
// FIFO entry layout {ext, brk, code}.
package bk_ps2_pkg;

    localparam int unsigned ENTRY_W = 10;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioning: 2-FF synchronizers on clock and data, a glitch
// filter on the clock, and a one-cycle strobe on each filtered falling edge.
// Ports:
//   clk, rst       - system clock, async active-high reset
//   ps2_clk        - raw PS/2 clock
//   ps2_data       - raw PS/2 data
//   data_s         - synchronized data, valid to sample when fall=1
//   fall           - one-cycle pulse on a filtered 1->0 clock transition
module ps2_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic             clk_meta;
    logic             clk_s;
    logic             data_meta;
    logic             filt;
    logic [CNT_W-1:0] cnt;

    // Synchronizers; both lines idle high on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_s     <= 1'b1;
            data_meta <= 1'b1;
            data_s    <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_s     <= clk_meta;
            data_meta <= ps2_data;
            data_s    <= data_meta;
        end
    end

    // The filtered level flips only after FILTER_LEN consecutive samples
    // disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                filt <= clk_s;
                cnt  <= '0;
                fall <= filt;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: frames scancodes off the PS/2 bus, folds E0/F0
// prefixes into ext/brk flags and queues {ext, brk, code} in a show-ahead FIFO.
// Optional feature macro: PS2_PARITY_CHECK_EN (enables odd-parity checking;
// when undefined the parity bit is sampled and ignored).
// Ports:
//   clk25, reset_in   - 25 MHz clock, async active-high reset
//   ps2_clk, ps2_data - raw PS/2 bus lines
//   code_o/ext_o/brk_o - FIFO head entry, zero when empty
//   valid_o           - FIFO not empty
//   read_i            - pop request
//   overflow_o        - sticky, a code was dropped; clears on next pop
//   err_o             - one-cycle pulse on a rejected frame
module ps2_rx_fifo
    import bk_ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic       clk25,
    input  logic       reset_in,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code_o,
    output logic       ext_o,
    output logic       brk_o,
    output logic       valid_o,
    input  logic       read_i,
    output logic       overflow_o,
    output logic       err_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic data_s;
    logic fall;

    ps2_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk      (clk25),
        .rst      (reset_in),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_s   (data_s),
        .fall     (fall)
    );

    ps2_state_t      state, state_nxt;
    logic [7:0]      shift_q, shift_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [TO_W-1:0] tcnt, tcnt_nxt;
    logic            par_bad, par_bad_nxt;
    logic            pend_ext, pend_ext_nxt;
    logic            pend_brk, pend_brk_nxt;
    logic            push_req, push_nxt;
    ps2_entry_t      push_entry, entry_nxt;
    logic            err_nxt;

    // Frame FSM next-state and datapath.
    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_q;
        bit_cnt_nxt  = bit_cnt;
        par_bad_nxt  = par_bad;
        pend_ext_nxt = pend_ext;
        pend_brk_nxt = pend_brk;
        push_nxt     = 1'b0;
        entry_nxt    = push_entry;
        err_nxt      = 1'b0;

        if (state == ST_IDLE || fall) begin
            tcnt_nxt = '0;
        end else begin
            tcnt_nxt = tcnt + TO_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (fall && !data_s) begin
                    state_nxt   = ST_DATA;
                    bit_cnt_nxt = 3'd0;
                    par_bad_nxt = 1'b0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_nxt   = {data_s, shift_q[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
                    par_bad_nxt = ~(^{shift_q, data_s});
`else
                    par_bad_nxt = 1'b0;
`endif
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_nxt = ST_IDLE;
                    if (!data_s || par_bad) begin
                        err_nxt      = 1'b1;
                        pend_ext_nxt = 1'b0;
                        pend_brk_nxt = 1'b0;
                    end else if (shift_q == PS2_PREFIX_EXT) begin
                        pend_ext_nxt = 1'b1;
                    end else if (shift_q == PS2_PREFIX_BRK) begin
                        pend_brk_nxt = 1'b1;
                    end else begin
                        push_nxt       = 1'b1;
                        entry_nxt.ext  = pend_ext;
                        entry_nxt.brk  = pend_brk;
                        entry_nxt.code = shift_q;
                        pend_ext_nxt   = 1'b0;
                        pend_brk_nxt   = 1'b0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Stalled frame: abandon it and drop any prefix context.
        if (state != ST_IDLE && !fall && tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_nxt    = ST_IDLE;
            err_nxt      = 1'b1;
            pend_ext_nxt = 1'b0;
            pend_brk_nxt = 1'b0;
        end
    end

    // Frame FSM registers.
    always_ff @(posedge clk25 or posedge reset_in) begin
        if (reset_in) begin
            state      <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            tcnt       <= '0;
            par_bad    <= 1'b0;
            pend_ext   <= 1'b0;
            pend_brk   <= 1'b0;
            push_req   <= 1'b0;
            push_entry <= '0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            tcnt       <= tcnt_nxt;
            par_bad    <= par_bad_nxt;
            pend_ext   <= pend_ext_nxt;
            pend_brk   <= pend_brk_nxt;
            push_req   <= push_nxt;
            push_entry <= entry_nxt;
            err_o      <= err_nxt;
        end
    end

    // FIFO: pointers carry one extra bit to tell full from empty.
    ps2_entry_t       mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             do_push;
    ps2_entry_t       head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = read_i && !empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_req && (!full || pop);

    always_ff @(posedge clk25) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk25 or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + (PTR_W + 1)'(1);
                overflow_o <= 1'b0;
            end else if (push_req && !do_push) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Show-ahead head, forced to zero when empty.
    assign head    = mem[rd_ptr[PTR_W-1:0]];
    assign valid_o = !empty;
    assign code_o  = valid_o ? head.code : 8'h00;
    assign ext_o   = valid_o ? head.ext  : 1'b0;
    assign brk_o   = valid_o ? head.brk  : 1'b0;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames bit by bit and checks
// the FIFO head, flags, error pulses, overflow, timeout and reset behaviour.
module tb_ps2_rx_fifo;

    localparam int HALF = 20;

    logic       clk25;
    logic       reset_in;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code_o;
    logic       ext_o;
    logic       brk_o;
    logic       valid_o;
    logic       read_i;
    logic       overflow_o;
    logic       err_o;

    int n_checks;
    int n_err;
    int cyc;
    int last_fall;
    int err_cnt;

    ps2_rx_fifo dut (
        .clk25      (clk25),
        .reset_in   (reset_in),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_o     (code_o),
        .ext_o      (ext_o),
        .brk_o      (brk_o),
        .valid_o    (valid_o),
        .read_i     (read_i),
        .overflow_o (overflow_o),
        .err_o      (err_o)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    always @(posedge clk25) begin
        cyc <= cyc + 1;
        if (err_o) err_cnt <= err_cnt + 1;
    end

    initial begin
        #(40 * 80000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF / 2) @(posedge clk25);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(posedge clk25);
        ps2_clk = 1'b1;
        repeat (HALF / 2) @(posedge clk25);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(bad_par ? (^code) : ~(^code));
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (20) @(posedge clk25);
        @(negedge clk25);
    endtask

    task automatic read_pulse();
        @(negedge clk25);
        read_i = 1'b1;
        @(negedge clk25);
        read_i = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] code,
                              input logic ext, input logic brk);
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_code"},  32'(code_o),  32'(code));
        check({tag, "_ext"},   32'(ext_o),   32'(ext));
        check({tag, "_brk"},   32'(brk_o),   32'(brk));
    endtask

    initial begin
        int e0;
        int lat;
        logic [7:0] exp_codes [4];
        n_checks = 0; n_err = 0; cyc = 0; err_cnt = 0; last_fall = 0;
        reset_in = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; read_i = 1'b0;
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_code", 32'(code_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        repeat (5) @(posedge clk25);
        @(negedge clk25);
        reset_in = 1'b0;
        repeat (5) @(negedge clk25);

        // Single good frame, then pop.
        send_frame(8'h1C, 1'b0);
        check_head("f1c", 8'h1C, 1'b0, 1'b0);
        read_pulse();
        check("f1c_popped", 32'(valid_o), 32'd0);
        check("f1c_empty_code", 32'(code_o), 32'd0);

        // Prefixes fold into one entry; a following plain code clears them.
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        check("prefix_not_pushed", 32'(valid_o), 32'd0);
        send_frame(8'h75, 1'b0);
        check_head("e0f075", 8'h75, 1'b1, 1'b1);
        read_pulse();
        send_frame(8'h75, 1'b0);
        check_head("plain75", 8'h75, 1'b0, 1'b0);
        read_pulse();
        check("plain75_popped", 32'(valid_o), 32'd0);

        // Bad parity.
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("badpar_err", 32'(err_cnt - e0), 32'd1);
        check("badpar_empty", 32'(valid_o), 32'd0);
`else
        check("badpar_noerr", 32'(err_cnt - e0), 32'd0);
        check_head("badpar_push", 8'h1C, 1'b0, 1'b0);
        read_pulse();
`endif

        // Overflow: five codes into a four-deep FIFO.
        exp_codes[0] = 8'h11; exp_codes[1] = 8'h22;
        exp_codes[2] = 8'h33; exp_codes[3] = 8'h44;
        for (int i = 0; i < 4; i++) send_frame(exp_codes[i], 1'b0);
        check("full_no_ovf", 32'(overflow_o), 32'd0);
        send_frame(8'h55, 1'b0);
        check("ovf_set", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("ovf_head%0d", i), exp_codes[i], 1'b0, 1'b0);
            read_pulse();
            check($sformatf("ovf_clr%0d", i), 32'(overflow_o), 32'd0);
        end
        check("ovf_drained", 32'(valid_o), 32'd0);

        // Timeout after four data bits.
        e0 = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        lat = -1;
        for (int i = 0; i < 26000; i++) begin
            @(negedge clk25);
            if (err_o) begin
                lat = cyc - last_fall;
                break;
            end
        end
        check("to_fired", 32'(lat >= 25000 && lat <= 25030), 32'd1);
        repeat (3) @(negedge clk25);
        check("to_one_pulse", 32'(err_cnt - e0), 32'd1);
        check("to_empty", 32'(valid_o), 32'd0);
        send_frame(8'h29, 1'b0);
        check_head("after_to", 8'h29, 1'b0, 1'b0);
        read_pulse();

        // Short glitches on ps2_clk while idle must not start a frame.
        e0 = err_cnt;
        ps2_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ps2_clk = 1'b0;
            repeat (3) @(posedge clk25);
            ps2_clk = 1'b1;
            repeat (10) @(posedge clk25);
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk25);
        check("glitch_noerr", 32'(err_cnt - e0), 32'd0);
        check("glitch_empty", 32'(valid_o), 32'd0);
        send_frame(8'h12, 1'b0);
        check_head("after_glitch", 8'h12, 1'b0, 1'b0);
        check("after_glitch_noerr", 32'(err_cnt - e0), 32'd0);

        // Reset mid-frame with an entry queued.
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        @(negedge clk25);
        reset_in = 1'b1;
        #1;
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_code", 32'(code_o), 32'd0);
        check("midrst_ext", 32'(ext_o), 32'd0);
        check("midrst_ovf", 32'(overflow_o), 32'd0);
        check("midrst_err", 32'(err_o), 32'd0);
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (4) @(negedge clk25);
        reset_in = 1'b0;
        repeat (10) @(negedge clk25);
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        check_head("after_rst", 8'h3C, 1'b0, 1'b0);
        check("after_rst_noerr", 32'(err_cnt - e0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
